lambdagen_issue_sched: RTL and testbench

//  Issue scheduler in front of the lambdagen triangle-setup pipeline. Round-robin arbitrates

---
 rtl/lambdagen_pkg.sv | 25 ++
 rtl/lambdagen_issue_sched_if.sv | 35 +++
 rtl/lg_tag_fifo.sv | 58 +++++
 rtl/lambdagen_issue_sched.sv | 126 ++++++++++++
 tb/tb_lambdagen_issue_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/lambdagen_pkg.sv
// Shared widths, lambdagen input_bus layout and scheduler state type.
package lambdagen_pkg;

   localparam int unsigned BUSW    = 128;
   localparam int unsigned FLD_W   = 16;
   localparam int unsigned TID_LSB = 112;
   localparam int unsigned Z1_LSB  = 96;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sched_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must hold the value n itself.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lambdagen_issue_sched_if.sv
// Request, lambdagen and control signals of the issue scheduler.
interface lambdagen_issue_sched_if #(
   parameter int unsigned NREQ = 4
);
   import lambdagen_pkg::*;

   localparam int unsigned SRCW = idx_w(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*BUSW-1:0] req_bus;
   logic                 stall_in;
   logic                 lg_valid;
   logic [BUSW-1:0]      lg_bus;
   logic                 lg_stall;
   logic                 lg_dovalid;
   logic                 res_valid;
   logic [SRCW-1:0]      res_src;
   logic                 credit_ret;
   logic                 flush;
   logic                 flush_done;
   logic                 idle;
   logic                 err;

   modport master (
      output req_valid, req_bus, stall_in, lg_dovalid, credit_ret, flush,
      input  req_ready, lg_valid, lg_bus, lg_stall, res_valid, res_src, flush_done, idle, err
   );

   modport slave (
      input  req_valid, req_bus, stall_in, lg_dovalid, credit_ret, flush,
      output req_ready, lg_valid, lg_bus, lg_stall, res_valid, res_src, flush_done, idle, err
   );

endinterface

// File: rtl/lg_tag_fifo.sv
// Synchronous FIFO holding the source tag of every triangle in flight.
module lg_tag_fifo
   import lambdagen_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [WIDTH-1:0]          din,
   output logic [WIDTH-1:0]          dout,
   output logic                      empty,
   output logic                      full,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int unsigned AW = idx_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wrap_inc(wr_ptr);
         if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
         if (do_push != do_pop) cnt <= do_push ? cnt + CW'(1) : cnt - CW'(1);
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign count = cnt;

endmodule

// File: rtl/lambdagen_issue_sched.sv
// Round-robin, credit-limited issue of triangle sources into lambdagen,
// with in-order result tagging and a flush/drain handshake.
module lambdagen_issue_sched
   import lambdagen_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned CREDITS = 8
) (
   input logic                    clk,
   input logic                    rst,
   lambdagen_issue_sched_if.slave io
);

   localparam int unsigned SRCW = idx_w(NREQ);
   localparam int unsigned CW   = cnt_w(CREDITS);

   sched_state_t    state_q, state_d;
   logic [SRCW-1:0] rr_q;
   logic [SRCW-1:0] grant;
   logic            grant_found;
   logic [CW-1:0]   credits_q, credits_d;
   logic [CW-1:0]   inflight, inflight_d;
   logic            issue_ok, fire, res_pop;
   logic            err_q, err_d;
   logic            flush_done_q, flush_done_d;
   logic            fifo_empty, fifo_full;
   logic [SRCW-1:0] fifo_head;

   // First valid source at or after the round-robin pointer.
   always_comb begin
      grant_found = 1'b0;
      grant       = rr_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!grant_found && io.req_valid[SRCW'((32'(rr_q) + i) % NREQ)]) begin
            grant_found = 1'b1;
            grant       = SRCW'((32'(rr_q) + i) % NREQ);
         end
      end
   end

   // flush is gated in directly so no grant is taken in the cycle it rises.
   assign issue_ok = (state_q == RUN) && !io.flush && !io.stall_in && !rst
                     && (credits_q != '0) && !fifo_full;
   assign fire     = issue_ok && grant_found;
   assign res_pop  = io.lg_dovalid && !io.stall_in && !fifo_empty;

   always_comb begin
      io.req_ready        = '0;
      io.req_ready[grant] = fire;
      io.lg_bus           = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant == SRCW'(i)) io.lg_bus = io.req_bus[i*BUSW +: BUSW];
      end
   end

   assign io.lg_valid   = fire;
   assign io.lg_stall   = io.stall_in;
   assign io.res_valid  = res_pop;
   assign io.res_src    = fifo_head;
   assign io.flush_done = flush_done_q;
   assign io.err        = err_q;
   assign io.idle       = (state_q == RUN) && (inflight == '0) && (credits_q == CW'(CREDITS));

   lg_tag_fifo #(
      .WIDTH (SRCW),
      .DEPTH (CREDITS)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fire),
      .pop   (res_pop),
      .din   (grant),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (inflight)
   );

   // Next state, credit accounting and sticky protocol error.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      credits_d    = credits_q;
      err_d        = err_q;
      inflight_d   = inflight + CW'(fire) - CW'(res_pop);

      case ({fire, io.credit_ret})
         2'b10:   credits_d = credits_q - CW'(1);
         2'b01:   if (credits_q != CW'(CREDITS)) credits_d = credits_q + CW'(1);
         default: credits_d = credits_q;
      endcase

      if ((io.lg_dovalid && !io.stall_in && fifo_empty) ||
          (io.credit_ret && (credits_q == CW'(CREDITS))))
         err_d = 1'b1;

      case (state_q)
         RUN:     if (io.flush) state_d = DRAIN;
         DRAIN: begin
            if (inflight_d == '0) begin
               state_d      = DONE;
               flush_done_d = 1'b1;
            end
         end
         DONE:    if (!io.flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         rr_q         <= '0;
         credits_q    <= CW'(CREDITS);
         err_q        <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         credits_q    <= credits_d;
         err_q        <= err_d;
         flush_done_q <= flush_done_d;
         if (fire) rr_q <= (grant == SRCW'(NREQ - 1)) ? '0 : grant + SRCW'(1);
      end
   end

endmodule

// File: tb/tb_lambdagen_issue_sched.sv
// Directed and random checks of lambdagen_issue_sched against a queue-based reference.
module tb_lambdagen_issue_sched;
   import lambdagen_pkg::*;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned CREDITS = 8;
   localparam int          LAT     = 7;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lambdagen_issue_sched_if #(.NREQ(NREQ)) io ();

   lambdagen_issue_sched #(
      .NREQ    (NREQ),
      .CREDITS (CREDITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state
   int   rr, credits, phase, cyc, fd_cyc;
   bit   pulse_due, err_m;
   bit   pipe [LAT];
   int   tags[$];
   int   fire_log[$], res_log[$], fire_cyc[$], res_cyc[$];
   logic [NREQ*BUSW-1:0] rbus;

   task automatic chk(input string tag, input logic [BUSW-1:0] obs, input logic [BUSW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input bit check);
      rst           = 1'b1;
      io.req_valid  = '1;
      io.req_bus    = '0;
      io.stall_in   = 1'b0;
      io.flush      = 1'b0;
      io.credit_ret = 1'b0;
      io.lg_dovalid = 1'b0;
      #2;
      if (check) begin
         chk("rst_req_ready", BUSW'(io.req_ready), '0);
         chk("rst_lg_valid", BUSW'(io.lg_valid), '0);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rr        = 0;
      credits   = CREDITS;
      phase     = 0;
      pulse_due = 1'b0;
      err_m     = 1'b0;
      fd_cyc    = -1;
      cyc       = 0;
      foreach (pipe[i]) pipe[i] = 1'b0;
      tags.delete();
      fire_log.delete();
      res_log.delete();
      fire_cyc.delete();
      res_cyc.delete();
   endtask

   // One clock: drive inputs, check against the reference, advance the reference.
   task automatic cycle(input logic [NREQ-1:0] v, input bit stall, input int cr_mode,
                        input bit fl, input bit dov_force);
      int              g;
      bit              fire, resv, cr, exp_idle;
      logic [NREQ-1:0] exp_ready;
      logic [BUSW-1:0] exp_bus;

      for (int i = 0; i < int'(NREQ); i++) begin
         for (int w = 0; w < int'(BUSW / 32); w++) rbus[i*BUSW + w*32 +: 32] = $urandom;
         rbus[i*BUSW + TID_LSB +: FLD_W] = FLD_W'(cyc);
      end
      io.req_valid  = v;
      io.req_bus    = rbus;
      io.stall_in   = stall;
      io.flush      = fl;
      io.lg_dovalid = pipe[LAT-1] | dov_force;

      g = -1;
      for (int k = 0; k < int'(NREQ); k++)
         if (g < 0 && v[(rr + k) % NREQ]) g = (rr + k) % NREQ;
      fire      = (g >= 0) && phase == 0 && !fl && !stall && credits > 0;
      exp_ready = fire ? (NREQ'(1) << g) : '0;
      exp_bus   = fire ? rbus[g*BUSW +: BUSW] : '0;
      resv      = io.lg_dovalid && !stall && tags.size() > 0;
      exp_idle  = phase == 0 && tags.size() == 0 && credits == CREDITS;
      case (cr_mode)
         1:       cr = resv;
         2:       cr = credits < CREDITS && $urandom_range(0, 2) == 0;
         3:       cr = 1'b1;
         default: cr = 1'b0;
      endcase
      io.credit_ret = cr;

      #2;
      chk("req_ready", BUSW'(io.req_ready), BUSW'(exp_ready));
      chk("lg_valid", BUSW'(io.lg_valid), BUSW'(fire));
      if (fire) chk("lg_bus", io.lg_bus, exp_bus);
      chk("lg_stall", BUSW'(io.lg_stall), BUSW'(stall));
      chk("res_valid", BUSW'(io.res_valid), BUSW'(resv));
      if (resv) chk("res_src", BUSW'(io.res_src), BUSW'(tags[0]));
      chk("flush_done", BUSW'(io.flush_done), BUSW'(pulse_due));
      chk("idle", BUSW'(io.idle), BUSW'(exp_idle));
      chk("err", BUSW'(io.err), BUSW'(err_m));
      if (io.flush_done === 1'b1) fd_cyc = cyc;

      if (io.lg_dovalid && !stall && tags.size() == 0) err_m = 1'b1;
      if (cr && credits == CREDITS) err_m = 1'b1;
      if (fire) begin
         tags.push_back(g);
         rr = (g + 1) % NREQ;
         fire_log.push_back(g);
         fire_cyc.push_back(cyc);
      end
      if (resv) begin
         res_log.push_back(tags.pop_front());
         res_cyc.push_back(cyc);
      end
      if (cr && !fire) begin
         if (credits < CREDITS) credits++;
      end else if (fire && !cr) begin
         credits--;
      end
      if (!stall) begin
         for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = fire;
      end
      pulse_due = 1'b0;
      case (phase)
         0: if (fl) phase = 1;
         1: if (tags.size() == 0) begin phase = 2; pulse_due = 1'b1; end
         default: if (!fl) phase = 0;
      endcase
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int f0, fl_left, exp_fd;

      do_reset(1'b0);

      // Continuous requests with credits returned as results arrive
      repeat (30) cycle('1, 1'b0, 1, 1'b0, 1'b0);
      chk("t1_fire_count", BUSW'(fire_log.size()), BUSW'(30));
      for (int i = 0; i < 8; i++) chk("t1_grant_seq", BUSW'(fire_log[i]), BUSW'(i % NREQ));
      for (int i = 0; i < 8; i++) chk("t1_res_seq", BUSW'(res_log[i]), BUSW'(i % NREQ));
      chk("t1_latency", BUSW'(res_cyc[0] - fire_cyc[0]), BUSW'(LAT));

      // Credit exhaustion and a single returned credit
      do_reset(1'b1);
      repeat (20) cycle('1, 1'b0, 0, 1'b0, 1'b0);
      chk("t2_fires", BUSW'(fire_log.size()), BUSW'(CREDITS));
      chk("t2_ready_zero", BUSW'(io.req_ready), '0);
      cycle('1, 1'b0, 3, 1'b0, 1'b0);
      repeat (10) cycle('1, 1'b0, 0, 1'b0, 1'b0);
      chk("t2_one_more", BUSW'(fire_log.size()), BUSW'(CREDITS + 1));

      // Stall with three in flight
      do_reset(1'b0);
      repeat (3) cycle('1, 1'b0, 1, 1'b0, 1'b0);
      repeat (4) cycle('0, 1'b0, 1, 1'b0, 1'b0);
      repeat (5) cycle('1, 1'b1, 1, 1'b0, 1'b0);
      chk("t3_no_res_in_stall", BUSW'(res_log.size()), '0);
      chk("t3_no_fire_in_stall", BUSW'(fire_log.size()), BUSW'(3));
      repeat (10) cycle('0, 1'b0, 1, 1'b0, 1'b0);
      chk("t3_res_count", BUSW'(res_log.size()), BUSW'(3));
      for (int i = 0; i < 3; i++) chk("t3_res_order", BUSW'(res_log[i]), BUSW'(i));

      // Flush with five in flight
      do_reset(1'b0);
      repeat (5) cycle('1, 1'b0, 1, 1'b0, 1'b0);
      f0 = fire_log.size();
      for (int i = 0; i < 20 && fd_cyc < 0; i++) cycle('1, 1'b0, 1, 1'b1, 1'b0);
      chk("t4_no_fire", BUSW'(fire_log.size()), BUSW'(f0));
      chk("t4_res_count", BUSW'(res_log.size()), BUSW'(5));
      exp_fd = (res_cyc.size() >= 5) ? res_cyc[4] + 1 : -2;
      chk("t4_done_timing", BUSW'(fd_cyc), BUSW'(exp_fd));
      repeat (2) cycle('1, 1'b0, 1, 1'b1, 1'b0);
      f0 = fire_log.size();
      repeat (5) cycle('1, 1'b0, 1, 1'b0, 1'b0);
      chk("t4_resume", BUSW'(fire_log.size() - f0), BUSW'(4));

      // Protocol errors
      do_reset(1'b0);
      cycle('0, 1'b0, 0, 1'b0, 1'b1);
      repeat (4) cycle('0, 1'b0, 0, 1'b0, 1'b0);
      chk("t5_err_sticky", BUSW'(io.err), BUSW'(1));
      do_reset(1'b1);
      cycle('0, 1'b0, 0, 1'b0, 1'b0);
      cycle('0, 1'b0, 3, 1'b0, 1'b0);
      cycle('0, 1'b0, 0, 1'b0, 1'b0);
      chk("t5_err_credit", BUSW'(io.err), BUSW'(1));

      // Reset mid-stream with four in flight
      do_reset(1'b0);
      repeat (4) cycle('1, 1'b0, 0, 1'b0, 1'b0);
      do_reset(1'b1);
      chk("t6_idle", BUSW'(io.idle), BUSW'(1));
      cycle('1, 1'b0, 0, 1'b0, 1'b0);
      chk("t6_first_grant", BUSW'(fire_log.size() > 0 ? fire_log[0] : -1), '0);

      // Random traffic, stalls, credit returns and flushes
      do_reset(1'b0);
      fl_left = 0;
      repeat (400) begin
         if (fl_left > 0) fl_left--;
         else if ($urandom_range(0, 59) == 0) fl_left = $urandom_range(3, 25);
         cycle(NREQ'($urandom), $urandom_range(0, 9) == 0, 2, fl_left > 0, 1'b0);
      end
      repeat (20) cycle('0, 1'b0, 2, 1'b0, 1'b0);
      chk("rnd_err_clear", BUSW'(io.err), '0);
      chk("rnd_all_returned", BUSW'(res_log.size()), BUSW'(fire_log.size()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
